// File: rtl/wakeup_bcast.sv
`default_nettype none
// ============================================================================
// Module   : wakeup_bcast
// Brief    : Issue-queue wake-up tag/delay broadcaster with mul occupancy,
//            single-outstanding ldst tracking and load-miss cancel/rebroadcast.
// Revision : 1.0 - initial release
// ============================================================================
module wakeup_bcast #(
   parameter int DLY_LEN = 8,
   parameter int ALU_LAT = 1,
   parameter int BRA_LAT = 1,
   parameter int LD_LAT  = 2,
   parameter int MUL_LAT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               iss_alu1_vld,
   input  logic               iss_alu2_vld,
   input  logic               iss_bra_vld,
   input  logic               iss_ldst_vld,
   input  logic               iss_mul_vld,
   input  logic [4:0]         iss_alu1_tag,
   input  logic [4:0]         iss_alu2_tag,
   input  logic [4:0]         iss_bra_tag,
   input  logic [4:0]         iss_ldst_tag,
   input  logic [4:0]         iss_mul_tag,
   input  logic               ldst_miss,
   input  logic               ldst_refill,
   output logic [4:0]         tag_alu1,
   output logic [4:0]         tag_alu2,
   output logic [4:0]         tag_bra,
   output logic [4:0]         tag_ldst,
   output logic [4:0]         tag_mul,
   output logic [DLY_LEN-1:0] delay_alu1,
   output logic [DLY_LEN-1:0] delay_alu2,
   output logic [DLY_LEN-1:0] delay_bra,
   output logic [DLY_LEN-1:0] delay_ldst,
   output logic [DLY_LEN-1:0] delay_mul,
   output logic               cancel_vld,
   output logic [4:0]         cancel_tag,
   output logic               mul_ready,
   output logic               ldst_ready
);

   localparam logic [DLY_LEN-1:0] c_dly_ones = {DLY_LEN{1'b1}};
   localparam logic [DLY_LEN-1:0] c_dly_alu  = c_dly_ones << (ALU_LAT - 1);
   localparam logic [DLY_LEN-1:0] c_dly_bra  = c_dly_ones << (BRA_LAT - 1);
   localparam logic [DLY_LEN-1:0] c_dly_ld   = c_dly_ones << (LD_LAT - 1);
   localparam logic [DLY_LEN-1:0] c_dly_mul  = c_dly_ones << (MUL_LAT - 1);

   localparam int                c_mul_cw  = $clog2(MUL_LAT + 1);
   localparam logic [c_mul_cw-1:0] c_mul_lat = c_mul_cw'(MUL_LAT);
   localparam logic [c_mul_cw-1:0] c_mul_one = c_mul_cw'(1);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_bcast  = 3'd1;
   localparam logic [2:0] c_st_check  = 3'd2;
   localparam logic [2:0] c_st_cancel = 3'd3;
   localparam logic [2:0] c_st_miss   = 3'd4;
   localparam logic [2:0] c_st_rebc   = 3'd5;

   logic [4:0]          r_tag_alu1, r_tag_alu2, r_tag_bra, r_tag_ldst, r_tag_mul;
   logic [DLY_LEN-1:0]  r_dly_alu1, r_dly_alu2, r_dly_bra, r_dly_ldst, r_dly_mul;
   logic                r_cancel_vld;
   logic [4:0]          r_cancel_tag;
   logic [c_mul_cw-1:0] r_mul_cnt;
   logic [2:0]          r_ld_state;
   logic [4:0]          r_pend_tag;

   logic                w_alu1_hit, w_alu2_hit, w_bra_hit;
   logic                w_mul_ready, w_mul_take, w_mul_hit;
   logic [2:0]          w_ld_state_nxt;
   logic [4:0]          w_pend_tag_nxt;
   logic [4:0]          w_ld_tag_nxt;
   logic [DLY_LEN-1:0]  w_ld_dly_nxt;
   logic                w_cancel_vld_nxt;
   logic [4:0]          w_cancel_tag_nxt;

   assign w_alu1_hit  = iss_alu1_vld && (iss_alu1_tag != 5'd0);
   assign w_alu2_hit  = iss_alu2_vld && (iss_alu2_tag != 5'd0);
   assign w_bra_hit   = iss_bra_vld  && (iss_bra_tag  != 5'd0);

   // A tag-0 mul issue still occupies the unit; only its broadcast is dropped.
   assign w_mul_ready = (r_mul_cnt == '0);
   assign w_mul_take  = iss_mul_vld && w_mul_ready;
   assign w_mul_hit   = w_mul_take && (iss_mul_tag != 5'd0);

   // Outputs are loaded on the transition into the state that owns them, so
   // the registered values line up with BCAST / CANCEL / REBC.
   always_comb begin
      w_ld_state_nxt   = r_ld_state;
      w_pend_tag_nxt   = r_pend_tag;
      w_ld_tag_nxt     = 5'd0;
      w_ld_dly_nxt     = '0;
      w_cancel_vld_nxt = 1'b0;
      w_cancel_tag_nxt = 5'd0;
      case (r_ld_state)
         c_st_idle: begin
            if (iss_ldst_vld) begin
               w_ld_state_nxt = c_st_bcast;
               w_pend_tag_nxt = iss_ldst_tag;
               if (iss_ldst_tag != 5'd0) begin
                  w_ld_tag_nxt = iss_ldst_tag;
                  w_ld_dly_nxt = c_dly_ld;
               end
            end
         end
         c_st_bcast: w_ld_state_nxt = c_st_check;
         c_st_check: begin
            if (ldst_miss) begin
               w_ld_state_nxt = c_st_cancel;
               if (r_pend_tag != 5'd0) begin
                  w_cancel_vld_nxt = 1'b1;
                  w_cancel_tag_nxt = r_pend_tag;
               end
            end else begin
               w_ld_state_nxt = c_st_idle;
            end
         end
         c_st_cancel: w_ld_state_nxt = c_st_miss;
         c_st_miss: begin
            if (ldst_refill) begin
               w_ld_state_nxt = c_st_rebc;
               if (r_pend_tag != 5'd0) begin
                  w_ld_tag_nxt = r_pend_tag;
                  w_ld_dly_nxt = c_dly_ones;
               end
            end
         end
         c_st_rebc: w_ld_state_nxt = c_st_idle;
         default:   w_ld_state_nxt = c_st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_tag_alu1   <= 5'd0;
         r_tag_alu2   <= 5'd0;
         r_tag_bra    <= 5'd0;
         r_tag_ldst   <= 5'd0;
         r_tag_mul    <= 5'd0;
         r_dly_alu1   <= '0;
         r_dly_alu2   <= '0;
         r_dly_bra    <= '0;
         r_dly_ldst   <= '0;
         r_dly_mul    <= '0;
         r_cancel_vld <= 1'b0;
         r_cancel_tag <= 5'd0;
         r_mul_cnt    <= '0;
         r_ld_state   <= c_st_idle;
         r_pend_tag   <= 5'd0;
      end else begin
         r_tag_alu1   <= w_alu1_hit ? iss_alu1_tag : 5'd0;
         r_dly_alu1   <= w_alu1_hit ? c_dly_alu : '0;
         r_tag_alu2   <= w_alu2_hit ? iss_alu2_tag : 5'd0;
         r_dly_alu2   <= w_alu2_hit ? c_dly_alu : '0;
         r_tag_bra    <= w_bra_hit ? iss_bra_tag : 5'd0;
         r_dly_bra    <= w_bra_hit ? c_dly_bra : '0;
         r_tag_mul    <= w_mul_hit ? iss_mul_tag : 5'd0;
         r_dly_mul    <= w_mul_hit ? c_dly_mul : '0;
         if (w_mul_take) begin
            r_mul_cnt <= c_mul_lat;
         end else if (!w_mul_ready) begin
            r_mul_cnt <= r_mul_cnt - c_mul_one;
         end
         r_ld_state   <= w_ld_state_nxt;
         r_pend_tag   <= w_pend_tag_nxt;
         r_tag_ldst   <= w_ld_tag_nxt;
         r_dly_ldst   <= w_ld_dly_nxt;
         r_cancel_vld <= w_cancel_vld_nxt;
         r_cancel_tag <= w_cancel_tag_nxt;
      end
   end

   assign tag_alu1   = r_tag_alu1;
   assign tag_alu2   = r_tag_alu2;
   assign tag_bra    = r_tag_bra;
   assign tag_ldst   = r_tag_ldst;
   assign tag_mul    = r_tag_mul;
   assign delay_alu1 = r_dly_alu1;
   assign delay_alu2 = r_dly_alu2;
   assign delay_bra  = r_dly_bra;
   assign delay_ldst = r_dly_ldst;
   assign delay_mul  = r_dly_mul;
   assign cancel_vld = r_cancel_vld;
   assign cancel_tag = r_cancel_tag;
   assign mul_ready  = w_mul_ready;
   assign ldst_ready = (r_ld_state == c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_wakeup_bcast.sv
`default_nettype none
// ============================================================================
// Module   : tb_wakeup_bcast
// Brief    : Self-checking bench for wakeup_bcast: vector table, directed
//            multi-cycle sequences and random traffic against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wakeup_bcast;

   localparam int DLY_LEN = 8;
   localparam int ALU_LAT = 1;
   localparam int BRA_LAT = 1;
   localparam int LD_LAT  = 2;
   localparam int MUL_LAT = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic [4:0]      vld = '0;          // 0 alu1, 1 alu2, 2 bra, 3 ldst, 4 mul
   logic [4:0][4:0] tg = '0;
   logic            miss = 1'b0;
   logic            refill = 1'b0;

   logic [4:0]         d_tag [5];
   logic [DLY_LEN-1:0] d_dly [5];
   logic               d_cv, d_mr, d_lr;
   logic [4:0]         d_ct;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   wakeup_bcast #(
      .DLY_LEN(DLY_LEN), .ALU_LAT(ALU_LAT), .BRA_LAT(BRA_LAT),
      .LD_LAT(LD_LAT), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .iss_alu1_vld(vld[0]), .iss_alu2_vld(vld[1]), .iss_bra_vld(vld[2]),
      .iss_ldst_vld(vld[3]), .iss_mul_vld(vld[4]),
      .iss_alu1_tag(tg[0]), .iss_alu2_tag(tg[1]), .iss_bra_tag(tg[2]),
      .iss_ldst_tag(tg[3]), .iss_mul_tag(tg[4]),
      .ldst_miss(miss), .ldst_refill(refill),
      .tag_alu1(d_tag[0]), .tag_alu2(d_tag[1]), .tag_bra(d_tag[2]),
      .tag_ldst(d_tag[3]), .tag_mul(d_tag[4]),
      .delay_alu1(d_dly[0]), .delay_alu2(d_dly[1]), .delay_bra(d_dly[2]),
      .delay_ldst(d_dly[3]), .delay_mul(d_dly[4]),
      .cancel_vld(d_cv), .cancel_tag(d_ct),
      .mul_ready(d_mr), .ldst_ready(d_lr)
   );

   string pn [5] = '{"alu1", "alu2", "bra", "ldst", "mul"};
   int    lat [5] = '{ALU_LAT, ALU_LAT, BRA_LAT, LD_LAT, MUL_LAT};

   // Reference: tracks the cycle the multiplier frees up and the age of the
   // outstanding load, and predicts the outputs visible one cycle later.
   int                 m_cyc = 0;
   int                 mul_free = 0;
   int                 ld_issue = -1;
   int                 ld_rebc = -1;
   logic [4:0]         ld_tag = '0;
   logic [4:0]         e_tag [5];
   logic [DLY_LEN-1:0] e_dly [5];
   logic               e_cv, e_mr, e_lr;
   logic [4:0]         e_ct;

   function automatic logic [DLY_LEN-1:0] dly(input int l);
      logic [DLY_LEN-1:0] ones;
      ones = '1;
      return ones << (l - 1);
   endfunction

   task automatic model_step();
      int age;
      for (int i = 0; i < 5; i++) begin
         e_tag[i] = '0;
         e_dly[i] = '0;
      end
      e_cv = 1'b0;
      e_ct = '0;
      if (rst || flush) begin
         mul_free = 0;
         ld_issue = -1;
         ld_rebc  = -1;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (vld[i] && tg[i] != 0) begin
               e_tag[i] = tg[i];
               e_dly[i] = dly(lat[i]);
            end
         end
         if (vld[4] && m_cyc >= mul_free) begin
            mul_free = m_cyc + 1 + MUL_LAT;
            if (tg[4] != 0) begin
               e_tag[4] = tg[4];
               e_dly[4] = dly(MUL_LAT);
            end
         end
         if (ld_issue < 0) begin
            if (vld[3]) begin
               ld_issue = m_cyc;
               ld_tag   = tg[3];
               ld_rebc  = -1;
               if (tg[3] != 0) begin
                  e_tag[3] = tg[3];
                  e_dly[3] = dly(LD_LAT);
               end
            end
         end else if (m_cyc == ld_rebc) begin
            ld_issue = -1;
         end else begin
            age = m_cyc - ld_issue;
            if (age == 2) begin
               if (miss) begin
                  if (ld_tag != 0) begin
                     e_cv = 1'b1;
                     e_ct = ld_tag;
                  end
               end else begin
                  ld_issue = -1;
               end
            end else if (age >= 4 && ld_rebc < 0 && refill) begin
               ld_rebc = m_cyc + 1;
               if (ld_tag != 0) begin
                  e_tag[3] = ld_tag;
                  e_dly[3] = '1;
               end
            end
         end
      end
      e_mr = (m_cyc + 1 >= mul_free);
      e_lr = (ld_issue < 0);
      m_cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, m_cyc, act, exp);
      else
         n_pass++;
   endtask

   task automatic compare_model();
      for (int i = 0; i < 5; i++) begin
         chk({"model_tag_", pn[i]}, 32'(d_tag[i]), 32'(e_tag[i]));
         chk({"model_delay_", pn[i]}, 32'(d_dly[i]), 32'(e_dly[i]));
      end
      chk("model_cancel_vld", 32'(d_cv), 32'(e_cv));
      chk("model_cancel_tag", 32'(d_ct), 32'(e_ct));
      chk("model_mul_ready", 32'(d_mr), 32'(e_mr));
      chk("model_ldst_ready", 32'(d_lr), 32'(e_lr));
   endtask

   // Inputs set before a call are sampled at its edge; outputs checked #1 later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; flush = 1'b0; vld = '0; tg = '0; miss = 1'b0; refill = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   typedef struct {
      logic                      flush;
      logic [4:0]                vld;
      logic [4:0][4:0]           tg;
      logic [4:0][4:0]           et;
      logic [4:0][DLY_LEN-1:0]   ed;
      logic                      emr;
      logic                      elr;
   } vec_t;

   vec_t vecs [7];

   initial begin
      // Packed order {mul, ldst, bra, alu2, alu1}
      vecs[0] = '{1'b0, 5'b00001, {5'd0,5'd0,5'd0,5'd0,5'd7}, {5'd0,5'd0,5'd0,5'd0,5'd7},
                  {8'h00,8'h00,8'h00,8'h00,8'hFF}, 1'b1, 1'b1};
      vecs[1] = '{1'b0, 5'b11111, {5'd5,5'd4,5'd3,5'd2,5'd1}, {5'd5,5'd4,5'd3,5'd2,5'd1},
                  {8'hF8,8'hFE,8'hFF,8'hFF,8'hFF}, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 5'b11111, {5'd5,5'd4,5'd3,5'd2,5'd1}, {5'd0,5'd0,5'd0,5'd0,5'd0},
                  {8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 5'b10000, {5'd0,5'd0,5'd0,5'd0,5'd0}, {5'd0,5'd0,5'd0,5'd0,5'd0},
                  {8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 5'b01000, {5'd0,5'd0,5'd0,5'd0,5'd0}, {5'd0,5'd0,5'd0,5'd0,5'd0},
                  {8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 5'b00110, {5'd0,5'd0,5'd0,5'd31,5'd0}, {5'd0,5'd0,5'd0,5'd31,5'd0},
                  {8'h00,8'h00,8'h00,8'hFF,8'h00}, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 5'b00000, {5'd5,5'd4,5'd3,5'd2,5'd1}, {5'd0,5'd0,5'd0,5'd0,5'd0},
                  {8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b1};

      do_reset();
      chk("reset_mul_ready", 32'(d_mr), 32'd1);
      chk("reset_ldst_ready", 32'(d_lr), 32'd1);
      chk("reset_cancel_vld", 32'(d_cv), 32'd0);

      foreach (vecs[k]) begin
         do_reset();
         flush = vecs[k].flush;
         vld   = vecs[k].vld;
         tg    = vecs[k].tg;
         cycle();
         for (int i = 0; i < 5; i++) begin
            chk({"vec_tag_", pn[i]}, 32'(d_tag[i]), 32'(vecs[k].et[i]));
            chk({"vec_delay_", pn[i]}, 32'(d_dly[i]), 32'(vecs[k].ed[i]));
         end
         chk("vec_mul_ready", 32'(d_mr), 32'(vecs[k].emr));
         chk("vec_ldst_ready", 32'(d_lr), 32'(vecs[k].elr));
         idle_inputs();
         cycle();
         chk("vec_alu1_cleared", 32'(d_tag[0]), 32'd0);
      end

      // Mul occupancy: second issue during busy window is dropped.
      do_reset();
      vld[4] = 1'b1; tg[4] = 5'd9;
      cycle();
      chk("mul_tag9", 32'(d_tag[4]), 32'd9);
      chk("mul_dly9", 32'(d_dly[4]), 32'hF8);
      idle_inputs();
      cycle();
      chk("mul_busy_n2", 32'(d_mr), 32'd0);
      vld[4] = 1'b1; tg[4] = 5'd10;
      cycle();
      chk("mul_tag10_dropped", 32'(d_tag[4]), 32'd0);
      idle_inputs();
      cycle();
      chk("mul_busy_n4", 32'(d_mr), 32'd0);
      cycle();
      chk("mul_ready_n5", 32'(d_mr), 32'd1);
      chk("mul_no_tag10", 32'(d_tag[4]), 32'd0);

      // Load hit.
      do_reset();
      vld[3] = 1'b1; tg[3] = 5'd3;
      cycle();
      chk("ld_hit_tag", 32'(d_tag[3]), 32'd3);
      chk("ld_hit_dly", 32'(d_dly[3]), 32'hFE);
      idle_inputs();
      cycle();
      cycle();
      chk("ld_hit_ready_n3", 32'(d_lr), 32'd1);
      chk("ld_hit_no_cancel", 32'(d_cv), 32'd0);

      // Load miss, early refill ignored, late refill rebroadcasts.
      do_reset();
      vld[3] = 1'b1; tg[3] = 5'd3;
      cycle();
      tg[3] = 5'd6;
      cycle();
      idle_inputs();
      miss = 1'b1;
      cycle();
      chk("ld_cancel_vld", 32'(d_cv), 32'd1);
      chk("ld_cancel_tag", 32'(d_ct), 32'd3);
      chk("ld_cancel_no_tag", 32'(d_tag[3]), 32'd0);
      miss = 1'b0; refill = 1'b1;
      cycle();
      chk("ld_miss_busy", 32'(d_lr), 32'd0);
      refill = 1'b0;
      cycle();
      cycle();
      refill = 1'b1;
      cycle();
      chk("ld_rebc_tag", 32'(d_tag[3]), 32'd3);
      chk("ld_rebc_dly", 32'(d_dly[3]), 32'hFF);
      refill = 1'b0;
      cycle();
      chk("ld_rebc_ready", 32'(d_lr), 32'd1);

      // Random traffic checked by the model every cycle.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst    = ($urandom_range(0, 127) == 0);
         flush  = ($urandom_range(0, 31) == 0);
         for (int i = 0; i < 5; i++) begin
            vld[i] = $urandom_range(0, 1) == 1;
            tg[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         end
         miss   = $urandom_range(0, 1) == 1;
         refill = ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
